// File: rtl/vc_arbiter_demux.sv
// vc_arbiter_demux
// Pops words from two virtual-channel FIFOs (VC0 strict priority, VC1 forced
// after STARVE_LIMIT consecutive VC0 grants while VC1 waits) and steers each
// word to destination FIFO D0 or D1 by bit DEST_BIT of the word. Hysteresis
// backpressure per destination comes from the destination flags.
//
// Ports:
//   clk, reset (async, active low), init (sync soft clear, 0 = clear)
//   vc0/vc1_empty, vc0/vc1_data      : VC FIFO read side (data valid cycle after pop)
//   d0/d1 full/almost_full/almost_empty/empty : destination status flags
//   pop_vc0, pop_vc1                 : combinational read enables
//   push_d0, push_d1, data_out       : registered write side to D0/D1
//   active                           : registered, a word is pending or being pushed
//   error                            : registered, sticky push-into-full flag
module vc_arbiter_demux #(
   parameter int data_width   = 6,
   parameter int DEST_BIT     = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  init,
   input  logic                  vc0_empty,
   input  logic                  vc1_empty,
   input  logic [data_width-1:0] vc0_data,
   input  logic [data_width-1:0] vc1_data,
   input  logic                  d0_full,
   input  logic                  d1_full,
   input  logic                  d0_almost_full,
   input  logic                  d1_almost_full,
   input  logic                  d0_almost_empty,
   input  logic                  d1_almost_empty,
   input  logic                  d0_empty,
   input  logic                  d1_empty,
   output logic                  pop_vc0,
   output logic                  pop_vc1,
   output logic                  push_d0,
   output logic                  push_d1,
   output logic [data_width-1:0] data_out,
   output logic                  active,
   output logic                  error
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic                  hold_d0_q, hold_d0_d;
   logic                  hold_d1_q, hold_d1_d;
   logic [3:0]            streak_q, streak_d;
   logic                  pend_q, pend_d;
   logic                  src_q, src_d;
   logic                  push_d0_q, push_d0_d;
   logic                  push_d1_q, push_d1_d;
   logic [data_width-1:0] data_out_q, data_out_d;
   logic                  active_q, active_d;
   logic                  error_q, error_d;

   logic                  stall;
   logic                  grant0, grant1;
   logic [data_width-1:0] word;

   // Raw almost_full/full participate directly so pops stop in the same cycle
   // the flag rises, not one cycle later when the hold flag catches up.
   always_comb begin
      stall = hold_d0_q | hold_d1_q | d0_almost_full | d1_almost_full | d0_full | d1_full;
   end

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset && init && !stall) begin
         if (streak_q == LIMIT && !vc1_empty) begin
            grant1 = 1'b1;
         end else if (!vc0_empty) begin
            grant0 = 1'b1;
         end else if (!vc1_empty) begin
            grant1 = 1'b1;
         end
      end
   end

   assign pop_vc0 = grant0;
   assign pop_vc1 = grant1;

   always_comb begin
      hold_d0_d  = hold_d0_q;
      hold_d1_d  = hold_d1_q;
      streak_d   = streak_q;
      pend_d     = grant0 | grant1;
      src_d      = grant1;
      word       = src_q ? vc1_data : vc0_data;
      push_d0_d  = 1'b0;
      push_d1_d  = 1'b0;
      data_out_d = data_out_q;

      // Set wins over clear when both flag groups are up together.
      if (d0_almost_full || d0_full) begin
         hold_d0_d = 1'b1;
      end else if (d0_almost_empty || d0_empty) begin
         hold_d0_d = 1'b0;
      end
      if (d1_almost_full || d1_full) begin
         hold_d1_d = 1'b1;
      end else if (d1_almost_empty || d1_empty) begin
         hold_d1_d = 1'b0;
      end

      // Streak only counts VC0 wins that made VC1 wait.
      if (grant1) begin
         streak_d = 4'd0;
      end else if (grant0) begin
         if (vc1_empty) begin
            streak_d = 4'd0;
         end else if (streak_q >= LIMIT) begin
            streak_d = LIMIT;
         end else begin
            streak_d = streak_q + 4'd1;
         end
      end

      if (pend_q) begin
         push_d0_d  = ~word[DEST_BIT];
         push_d1_d  = word[DEST_BIT];
         data_out_d = word;
      end

      error_d  = error_q | (push_d0_d & d0_full) | (push_d1_d & d1_full);
      active_d = pend_d | push_d0_d | push_d1_d;

      if (!init) begin
         hold_d0_d  = 1'b0;
         hold_d1_d  = 1'b0;
         streak_d   = 4'd0;
         pend_d     = 1'b0;
         src_d      = 1'b0;
         push_d0_d  = 1'b0;
         push_d1_d  = 1'b0;
         data_out_d = '0;
         error_d    = 1'b0;
         active_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_d0_q  <= 1'b0;
         hold_d1_q  <= 1'b0;
         streak_q   <= 4'd0;
         pend_q     <= 1'b0;
         src_q      <= 1'b0;
         push_d0_q  <= 1'b0;
         push_d1_q  <= 1'b0;
         data_out_q <= '0;
         active_q   <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         hold_d0_q  <= hold_d0_d;
         hold_d1_q  <= hold_d1_d;
         streak_q   <= streak_d;
         pend_q     <= pend_d;
         src_q      <= src_d;
         push_d0_q  <= push_d0_d;
         push_d1_q  <= push_d1_d;
         data_out_q <= data_out_d;
         active_q   <= active_d;
         error_q    <= error_d;
      end
   end

   assign push_d0  = push_d0_q;
   assign push_d1  = push_d1_q;
   assign data_out = data_out_q;
   assign active   = active_q;
   assign error    = error_q;

endmodule
